// File: rtl/alu_74181_seq.sv
// Nibble-serial sequencer driving one shared 74181 slice across a WIDTH-bit operand pair.
// Latency: accept at edge T, out_valid seen at edge T+NIBBLES+1; one op per NIBBLES+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until return to IDLE.
module alu_74181_seq #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             busy,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         s_q, s_d;
  logic               m_q, m_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  // Next-state: latch request in IDLE, fold one ALU nibble per RUN cycle, hold result in DONE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    m_d         = m_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          s_d     = op_s;
          m_d     = op_m;
          carry_d = op_cn;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = alu_f;
        carry_d                = alu_cout;
        idx_d                  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Zero flag must see the nibble being written this cycle, hence result_d.
          carry_out_d = alu_cout;
          zero_d      = (result_d == '0);
          idx_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake/status flags are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State register with synchronous active-low reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      m_q         <= m_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // ALU slice inputs: current nibble in RUN, otherwise quiet with CN high (no carry in).
  always_comb begin
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    alu_s  = 4'h0;
    alu_m  = 1'b0;
    alu_cn = 1'b1;
    if (state_q == RUN) begin
      alu_a  = a_q[4*idx_q +: 4];
      alu_b  = b_q[4*idx_q +: 4];
      alu_s  = s_q;
      alu_m  = m_q;
      alu_cn = carry_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_74181_seq.sv
// Bench for alu_74181_seq: behavioural 74181 slice on the ALU port, word-level reference model,
// expected responses queued at issue time and checked by an independent output monitor.
module tb_alu_74181_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   op_s;
  logic         op_m, op_cn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out, zero, busy;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cn, alu_cout;

  alu_74181_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cn(op_cn),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 74181 slice, active-high data: bitwise propagate/generate terms, CN/Cout active-low.
  function automatic logic [4:0] alu_slice(input logic [3:0] a, b, s, input logic m, cn);
    logic [3:0] p, g;
    logic [4:0] sum;
    p   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    g   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, p} + {1'b0, g} + {4'b0, ~cn};
    return {~sum[4], (m ? ~(p ^ g) : sum[3:0])};
  endfunction

  assign {alu_cout, alu_f} = alu_slice(alu_a, alu_b, alu_s, alu_m, alu_cn);

  // Word-level datasheet operands: arithmetic F = X + Y + carry.
  function automatic logic [2*W-1:0] ref_xy(input logic [W-1:0] a, b, input logic [3:0] s);
    logic [W-1:0] x, y;
    case (s[1:0])
      2'd0:    x = a;
      2'd1:    x = a | b;
      2'd2:    x = a | ~b;
      default: x = '1;
    endcase
    case (s[3:2])
      2'd0:    y = '0;
      2'd1:    y = a & ~b;
      2'd2:    y = a & b;
      default: y = a;
    endcase
    return {x, y};
  endfunction

  // Reference: returns {carry_out (ALU polarity), zero, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, b, input logic [3:0] s,
                                          input logic m, cn);
    logic [W-1:0] x, y, f;
    logic [W:0]   sum;
    {x, y} = ref_xy(a, b, s);
    sum = {1'b0, x} + {1'b0, y} + (W+1)'(!cn);
    if (!m) f = sum[W-1:0];
    else begin
      case (s)
        4'd0:  f = ~a;          4'd1:  f = ~(a | b);
        4'd2:  f = ~a & b;      4'd3:  f = '0;
        4'd4:  f = ~(a & b);    4'd5:  f = ~b;
        4'd6:  f = a ^ b;       4'd7:  f = a & ~b;
        4'd8:  f = ~a | b;      4'd9:  f = ~(a ^ b);
        4'd10: f = b;           4'd11: f = a & b;
        4'd12: f = '1;          4'd13: f = a | ~b;
        4'd14: f = a | b;       default: f = a;
      endcase
    end
    return {~sum[W], (f == '0), f};
  endfunction

  // Expected CN seen by nibble k: inverse of the word-level carry into bit 4k.
  function automatic logic ref_cn(input logic [W-1:0] a, b, input logic [3:0] s,
                                  input logic cn, input int k);
    logic [W-1:0] x, y;
    logic [W:0]   mask, csum;
    {x, y} = ref_xy(a, b, s);
    mask = ((W+1)'(1) << (4 * k)) - 1'b1;
    csum = ({1'b0, x} & mask) + ({1'b0, y} & mask) + (W+1)'(!cn);
    return ~csum[4*k];
  endfunction

  typedef struct packed { logic co; logic z; logic [W-1:0] res; } exp_t;
  typedef struct packed { logic [3:0] a; logic [3:0] b; logic cn; } nib_t;

  exp_t exp_q[$];
  nib_t nib_q[$];
  int   acc_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // out_ready driver: fixed level from rdy_val, or random when rdy_rand is set.
  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Issue one request; queue expectations unless track is clear (aborted request).
  task automatic send(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cn,
                      input bit track);
    int n;
    logic [W+1:0] r;
    n = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cn = cn; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      fail_now("send_timeout");
      in_valid = 1'b0;
    end else begin
      r = ref_op(a, b, s, m, cn);
      if (track) begin
        exp_q.push_back(exp_t'(r));
        acc_q.push_back(cyc + 1);
      end
      for (int k = 0; k < NIBBLES; k++)
        nib_q.push_back({a[4*k +: 4], b[4*k +: 4], ref_cn(a, b, s, cn, k)});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); op_s = 4'($urandom);
      op_m = 1'($urandom); op_cn = 1'($urandom);
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("out_valid_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || nib_q.size() != 0 || busy !== 1'b0 || in_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, b, input logic [3:0] s,
                          input logic m, cn, input logic [W-1:0] e_res, input logic e_co, e_z);
    send(a, b, s, m, cn, 1'b1);
    wait_out();
    chk({name, "_result"}, result, e_res);
    chk({name, "_carry"}, carry_out, e_co);
    chk({name, "_zero"}, zero, e_z);
    drain();
  endtask

  // Monitor: ALU-port sequence during RUN, hold stability, latency and result scoreboard.
  bit           mon_en = 1'b0;
  bit           hold_prev = 1'b0;
  bit           ov_prev = 1'b0;
  logic [W-1:0] hold_res;
  logic         hold_co, hold_z;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy && !out_valid) begin
          if (nib_q.size() == 0) fail_now("unexpected_run");
          else begin
            nib_t e;
            e = nib_q.pop_front();
            chk("run_alu_a", alu_a, e.a);
            chk("run_alu_b", alu_b, e.b);
            chk("run_alu_cn", alu_cn, e.cn);
          end
        end else begin
          chk("quiet_alu_cn", alu_cn, 1);
          chk("quiet_alu_a", alu_a, 0);
        end
        if (hold_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_result", result, hold_res);
          chk("hold_carry", carry_out, hold_co);
          chk("hold_zero", zero, hold_z);
          chk("hold_in_ready", in_ready, 0);
        end
        if (out_valid && !ov_prev) begin
          if (acc_q.size() == 0) fail_now("spurious_out_valid");
          else chk("latency", 32'(cyc + 1 - acc_q.pop_front()), NIBBLES + 1);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_result", result, e.res);
            chk("sb_carry", carry_out, e.co);
            chk("sb_zero", zero, e.z);
          end
        end
        hold_prev = out_valid && !out_ready;
        ov_prev   = out_valid;
        hold_res  = result;
        hold_co   = carry_out;
        hold_z    = zero;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1;
    op_a = 16'h1111; op_b = 16'h2222; op_s = 4'h9; op_m = 1'b0; op_cn = 1'b1;
    // Reset held two clocks with a request pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_cn", alu_cn, 1);
    end
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_zero", zero, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_accept", busy, 0);
    mon_en = 1'b1;

    // Add with per-nibble CN sequence 1,0,0,0.
    send(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      chk("add_alu_cn", alu_cn, (k == 0) ? 1 : 0);
    end
    wait_out();
    chk("add_result", result, 16'h2233);
    chk("add_carry", carry_out, 1);
    chk("add_zero", zero, 0);
    drain();

    directed("ovf", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    directed("cin", 16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0);
    send(16'h00FF, 16'h1234, 4'b0000, 1'b1, 1'b1, 1'b1);
    wait_out();
    chk("logic_result", result, 16'hFF00);
    drain();

    // Backpressure: result held six clocks while a second request waits.
    rdy_val = 1'b0;
    send(16'hA5A5, 16'h0F0F, 4'b0110, 1'b0, 1'b1, 1'b1);
    fork
      send(16'h7777, 16'h8889, 4'b1001, 1'b0, 1'b1, 1'b1);
    join_none
    wait_out();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    rdy_val = 1'b1;
    drain();

    // Abort at RUN idx 2.
    send(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    rst_n = 1'b1;
    nib_q.delete();
    repeat (8) @(negedge clk);
    chk("abort_no_valid", out_valid, 0);

    // Randomised operations with random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++)
      send(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    drain();
    repeat (4) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
